countdown_sequencer: RTL and testbench

- Initiator/controller for the team's 3-bit loadable down counter.
- Accepts countdown requests over a valid/ready handshake, then drives the counter's load, count_to and count_en inputs, with count_en rate-limited by a prescaler.
- Watches the counter's done output; on completion it reports a one-cycle expire pulse and optionally re-arms (repeat mode).
- Includes a watchdog that flags a counter that never reports done.

---
 rtl/countdown_sequencer_if.sv | 27 ++
 rtl/countdown_sequencer.sv | 135 +++++++++++++
 tb/tb_countdown_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_sequencer_if.sv
// Request channel of the countdown sequencer: valid/ready handshake
// carrying the start value, repeat flag and prescale for one countdown.
interface countdown_sequencer_if #(
    parameter int PRESCALE_W = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2:0]            req_value;
    logic                  req_repeat;
    logic [PRESCALE_W-1:0] req_prescale;

    modport master (
        output req_valid,
        output req_value,
        output req_repeat,
        output req_prescale,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_value,
        input  req_repeat,
        input  req_prescale,
        output req_ready
    );
endinterface

// File: rtl/countdown_sequencer.sv
// Controller for the 3-bit loadable down counter: loads it, paces its
// enables through a prescaler, reports expiries and watches for a stuck done.
module countdown_sequencer #(
    parameter int PRESCALE_W = 4,
    parameter int EXP_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    countdown_sequencer_if.slave req,
    input  logic                 cancel,
    input  logic                 err_clr,
    output logic                 cnt_load,
    output logic [2:0]           cnt_count_to,
    output logic                 cnt_count_en,
    input  logic                 cnt_done,
    output logic                 busy,
    output logic                 expire,
    output logic [EXP_CNT_W-1:0] expire_cnt,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            value_q;
    logic                  repeat_q;
    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] pc_q;
    logic [3:0]            ecnt_q;
    logic [EXP_CNT_W-1:0]  expire_cnt_q;
    logic                  err_q;

    logic accept;
    logic pc_wrap;
    logic wd_trip;
    logic wd_fire;

    assign accept  = (state_q == IDLE) & req.req_valid;
    assign pc_wrap = (pc_q == presc_q);
    // A healthy counter is done after N+1 enables; one more means it is stuck.
    assign wd_trip = (ecnt_q == ({1'b0, value_q} + 4'd2));
    assign wd_fire = (state_q == RUN) & ~cancel & ~cnt_done & wd_trip;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req.req_valid) state_d = LOAD;
            end
            LOAD: begin
                state_d = cancel ? IDLE : RUN;
            end
            RUN: begin
                if (cancel)        state_d = IDLE;
                else if (cnt_done) state_d = DONE;
                else if (wd_trip)  state_d = IDLE;
            end
            DONE: begin
                state_d = (repeat_q & ~cancel) ? LOAD : IDLE;
            end
        endcase
    end

    always_comb begin
        req.req_ready = 1'b0;
        busy          = 1'b1;
        cnt_load      = 1'b0;
        cnt_count_to  = '0;
        cnt_count_en  = 1'b0;
        expire        = 1'b0;
        unique case (state_q)
            IDLE: begin
                req.req_ready = 1'b1;
                busy          = 1'b0;
            end
            LOAD: begin
                cnt_load     = 1'b1;
                cnt_count_to = value_q;
            end
            RUN: begin
                cnt_count_en = pc_wrap & ~cnt_done & ~cancel & ~wd_trip;
            end
            DONE: begin
                expire = ~cancel;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q      <= '0;
            repeat_q     <= 1'b0;
            presc_q      <= '0;
            pc_q         <= '0;
            ecnt_q       <= '0;
            expire_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                value_q  <= req.req_value;
                repeat_q <= req.req_repeat;
                presc_q  <= req.req_prescale;
            end
            if (state_q == LOAD) begin
                pc_q   <= '0;
                ecnt_q <= '0;
            end else if (state_q == RUN) begin
                pc_q <= pc_wrap ? '0 : pc_q + PRESCALE_W'(1);
                if (cnt_count_en) ecnt_q <= ecnt_q + 4'd1;
            end
            if (expire && (expire_cnt_q != '1)) begin
                expire_cnt_q <= expire_cnt_q + EXP_CNT_W'(1);
            end
            if (wd_fire)      err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
        end
    end

    assign expire_cnt = expire_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: vector table, hand-written corner
// sequences and randomized requests against a schedule-based model.
module tb_countdown_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cancel;
    logic       err_clr;
    logic       cnt_load;
    logic [2:0] cnt_count_to;
    logic       cnt_count_en;
    logic       cnt_done;
    logic       busy;
    logic       expire;
    logic [7:0] expire_cnt;
    logic       err;

    countdown_sequencer_if #(.PRESCALE_W(4)) rif ();

    countdown_sequencer #(
        .PRESCALE_W(4),
        .EXP_CNT_W (8)
    ) dut (
        .clk         (clk),
        .reset_n     (rst_n),
        .req         (rif),
        .cancel      (cancel),
        .err_clr     (err_clr),
        .cnt_load    (cnt_load),
        .cnt_count_to(cnt_count_to),
        .cnt_count_en(cnt_count_en),
        .cnt_done    (cnt_done),
        .busy        (busy),
        .expire      (expire),
        .expire_cnt  (expire_cnt),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub of the down counter: done after count_to+1 enables, or never when broken.
    logic       broken;
    logic [3:0] rem;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            cnt_done <= 1'b0;
        end else if (cnt_load) begin
            rem      <= {1'b0, cnt_count_to} + 4'd1;
            cnt_done <= 1'b0;
        end else if (cnt_count_en && !broken) begin
            rem <= rem - 4'd1;
            if (rem == 4'd1) cnt_done <= 1'b1;
        end
    end

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       load;
        logic       en;
        logic       exp;
        logic [2:0] cto;
    } obs_t;

    obs_t act_o;
    assign act_o = {rif.req_ready, busy, cnt_load, cnt_count_en, expire, cnt_count_to};

    typedef struct {
        logic       v;
        logic [2:0] n;
        logic [3:0] p;
        logic       can;
        obs_t       e;
        int         ec;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int exp_m    = 0;
    int err_m    = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, want);
        end
    endtask

    function automatic obs_t mk_o(int r, int b, int l, int en, int x, int cto);
        obs_t o;
        o.ready = r[0];
        o.busy  = b[0];
        o.load  = l[0];
        o.en    = en[0];
        o.exp   = x[0];
        o.cto   = cto[2:0];
        return o;
    endfunction

    function automatic vec_t mk(int v, int n, int p, int can, obs_t e, int ec);
        vec_t t;
        t.v   = v[0];
        t.n   = n[2:0];
        t.p   = p[3:0];
        t.can = can[0];
        t.e   = e;
        t.ec  = ec;
        return t;
    endfunction

    // Expected outputs c cycles after a handshake, from the latency rules:
    // period L, load at offset 1, enables at 2+P+j(P+1), expire at offset L.
    function automatic obs_t model(int c, int n, int p, bit rep, int can);
        obs_t o;
        int   len, m, r, k;
        bit   act;
        o       = '0;
        o.ready = 1'b1;
        if (c == 0) return o;
        len = 3 + (n + 1) * (p + 1);
        m   = c - 1;
        r   = m % len + 1;
        act = (rep || (m / len) == 0) && (can < 0 || c <= can);
        if (!act) return o;
        o.ready = 1'b0;
        o.busy  = 1'b1;
        o.load  = (r == 1);
        o.cto   = (r == 1) ? n[2:0] : 3'd0;
        k       = r - 2 - p;
        o.en    = (k >= 0) && (k % (p + 1) == 0) && (k / (p + 1) <= n) && (c != can);
        o.exp   = (r == len) && (c != can);
        return o;
    endfunction

    task automatic run_sched(int n, int p, bit rep, int total, int can);
        obs_t e;
        for (int c = 0; c < total; c++) begin
            e = model(c, n, p, rep, can);
            err_clr = 1'b0;
            if (c == 0) begin
                rif.req_valid    = 1'b1;
                rif.req_value    = 3'(n);
                rif.req_repeat   = rep;
                rif.req_prescale = 4'(p);
                cancel           = 1'($urandom_range(0, 1));
            end else if (e.busy) begin
                rif.req_valid    = 1'($urandom_range(0, 1));
                rif.req_value    = 3'($urandom);
                rif.req_repeat   = 1'($urandom);
                rif.req_prescale = 4'($urandom);
                cancel           = (c == can);
            end else begin
                rif.req_valid = 1'b0;
                cancel        = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("sched_n%0d_p%0d_c%0d", n, p, c), 32'(act_o), 32'(e));
            chk("sched_expire_cnt", 32'(expire_cnt), exp_m);
            chk("sched_err", 32'(err), err_m);
            if (e.exp && exp_m < 255) exp_m++;
            @(posedge clk);
            #1;
        end
        cancel = 1'b0;
    endtask

    task automatic wd_run(int n, int p, bit clr);
        int w, ens;
        w      = 3 + p + (n + 1) * (p + 1);
        ens    = 0;
        broken = 1'b1;
        for (int c = 0; c <= w + 1; c++) begin
            rif.req_valid    = (c == 0);
            rif.req_value    = 3'(n);
            rif.req_repeat   = 1'b1;
            rif.req_prescale = 4'(p);
            cancel           = 1'b0;
            err_clr          = clr;
            @(negedge clk);
            ens += int'(cnt_count_en);
            if (c == w + 1) begin
                chk("wd_busy", 32'(busy), 0);
                chk("wd_err_set", 32'(err), 1);
            end else begin
                chk("wd_no_expire", 32'(expire), 0);
            end
            @(posedge clk);
            #1;
        end
        chk("wd_enables", ens, n + 2);
        broken  = 1'b0;
        err_clr = 1'b0;
        if (clr) begin
            @(negedge clk);
            chk("wd_err_cleared", 32'(err), 0);
            err_m = 0;
            @(posedge clk);
            #1;
        end else begin
            err_m = 1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("wd_err_sticky", 32'(err), 1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        rst_n            = 1'b0;
        broken           = 1'b0;
        cancel           = 1'b0;
        err_clr          = 1'b0;
        rif.req_valid    = 1'b0;
        rif.req_value    = '0;
        rif.req_repeat   = 1'b0;
        rif.req_prescale = '0;

        // N=3 P=0, then N=0 P=2 with an ignored cancel at the handshake
        tbl.push_back(mk(1, 3, 0, 0, mk_o(1, 0, 0, 0, 0, 0), 0));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 1, 0, 0, 3), 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 0, 1, 0, 0), 0));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 0, 0, 0, 0), 0));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 0, 0, 1, 0), 0));
        tbl.push_back(mk(1, 0, 2, 1, mk_o(1, 0, 0, 0, 0, 0), 1));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 1, 0, 0, 0), 1));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 0, 0, 0, 0), 1));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 0, 0, 0, 0), 1));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 0, 1, 0, 0), 1));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 0, 0, 0, 0), 1));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(0, 1, 0, 0, 1, 0), 1));
        tbl.push_back(mk(0, 0, 0, 0, mk_o(1, 0, 0, 0, 0, 0), 2));

        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'(act_o), 32'(mk_o(1, 0, 0, 0, 0, 0)));
        chk("reset_expire_cnt", 32'(expire_cnt), 0);
        chk("reset_err", 32'(err), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            rif.req_valid    = tbl[i].v;
            rif.req_value    = tbl[i].n;
            rif.req_repeat   = 1'b0;
            rif.req_prescale = tbl[i].p;
            cancel           = tbl[i].can;
            err_clr          = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(act_o), 32'(tbl[i].e));
            chk($sformatf("vec%0d_ecnt", i), 32'(expire_cnt), tbl[i].ec);
            @(posedge clk);
            #1;
        end
        cancel = 1'b0;
        exp_m  = 2;

        // N=2 P=1 repeat: three expiries, cancel one cycle before the fourth
        run_sched(2, 1, 1'b1, 37, 35);
        chk("repeat_expire_cnt", 32'(expire_cnt), 5);

        wd_run(5, 0, 1'b0);
        run_sched(2, 0, 1'b0, 8, -1);

        rif.req_valid    = 1'b1;
        rif.req_value    = 3'd4;
        rif.req_repeat   = 1'b0;
        rif.req_prescale = 4'd3;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'(act_o), 32'(mk_o(1, 0, 0, 0, 0, 0)));
        chk("async_rst_expire_cnt", 32'(expire_cnt), 0);
        chk("async_rst_err", 32'(err), 0);
        exp_m = 0;
        err_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_sched(1, 0, 1'b0, 7, -1);

        wd_run(0, 0, 1'b1);

        for (int it = 0; it < 40; it++) begin
            int n, p, len, can, tot;
            bit rep;
            n   = $urandom_range(0, 7);
            p   = $urandom_range(0, 15);
            rep = 1'($urandom_range(0, 1));
            len = 3 + (n + 1) * (p + 1);
            if (rep) can = $urandom_range(1, 3 * len);
            else if ($urandom_range(0, 3) == 0) can = $urandom_range(1, len);
            else can = -1;
            tot = (can < 0) ? len + 2 : can + 2;
            run_sched(n, p, rep, tot, can);
        end

        // N=0 P=0 repeat long enough to pass the saturation point
        run_sched(0, 0, 1'b1, 1052, 1050);
        chk("expire_cnt_saturated", 32'(expire_cnt), 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
